// File: rtl/quad_encoder_gen.sv
// quad_encoder_gen: quadrature encoder waveform generator driven by step commands
// Ports: clk; rst (async, active-low, release synchronised);
//   cmd_valid/cmd_ready handshake with cmd_dir, cmd_steps, cmd_dwell; abort;
//   enc_a/enc_b registered quadrature outputs; busy; done pulse; signed position.
module quad_encoder_gen #(
  parameter int STEP_W = 16,
  parameter int CNT_W  = 16,
  parameter int POS_W  = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic [CNT_W-1:0]  cmd_dwell,
  input  logic              abort,
  output logic              enc_a,
  output logic              enc_b,
  output logic              busy,
  output logic              done,
  output logic [POS_W-1:0]  position
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;
  logic [1:0]        sync_q, sync_d;
  logic [1:0]        state_q, state_d;
  logic              dir_q, dir_d;
  logic [STEP_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0]  dwell_q, dwell_d, cnt_q, cnt_d, dwell_eff;
  logic [1:0]        phase_q, phase_d;
  logic [POS_W-1:0]  pos_q, pos_d;
  logic              accept, step, run;
  always_comb begin
    sync_d    = {sync_q[0], 1'b1};
    run       = state_q == RUN;
    accept    = cmd_valid && cmd_ready;
    dwell_eff = cmd_dwell == '0 ? CNT_W'(1) : cmd_dwell;
    // A step fires on the last dwell clock; a run with no steps left just drains to FIN.
    step      = run && rem_q != '0 && cnt_q == CNT_W'(1);
    state_d   = state_q == IDLE ? (accept ? RUN : IDLE) :
                run ? ((abort || rem_q == '0) ? FIN : RUN) : IDLE;
    dir_d     = accept ? cmd_dir : dir_q;
    rem_d     = accept ? cmd_steps : step ? rem_q - STEP_W'(1) : rem_q;
    dwell_d   = accept ? dwell_eff : dwell_q;
    cnt_d     = accept ? dwell_eff : !run ? cnt_q :
                cnt_q == CNT_W'(1) ? dwell_q : cnt_q - CNT_W'(1);
    // Forward: {a,b} <= {~b,a}; reverse: {a,b} <= {b,~a}. Only one bit changes.
    phase_d   = !step ? phase_q : dir_q ? {~phase_q[0], phase_q[1]} : {phase_q[0], ~phase_q[1]};
    pos_d     = !step ? pos_q : pos_q + (dir_q ? POS_W'(1) : {POS_W{1'b1}});
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '0;
      state_q <= IDLE;
      dir_q   <= 1'b0;
      rem_q   <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
      phase_q <= '0;
      pos_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      dir_q   <= dir_d;
      rem_q   <= rem_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      pos_q   <= pos_d;
    end
  end
  assign cmd_ready = state_q == IDLE && sync_q[1];
  assign busy      = state_q == RUN;
  assign done      = state_q == FIN;
  assign enc_a     = phase_q[1];
  assign enc_b     = phase_q[0];
  assign position  = pos_q;
endmodule

// File: tb/tb_quad_encoder_gen.sv
// tb_quad_encoder_gen: directed self-checking bench for quad_encoder_gen
module tb_quad_encoder_gen;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_dir = 1'b0;
  logic [15:0] cmd_steps = '0;
  logic [15:0] cmd_dwell = '0;
  logic        abort = 1'b0;
  logic        enc_a, enc_b, busy, done;
  logic [23:0] position;
  int n_cmp = 0;
  int n_bad = 0;

  quad_encoder_gen dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .cmd_dwell(cmd_dwell),
    .abort(abort), .enc_a(enc_a), .enc_b(enc_b), .busy(busy), .done(done),
    .position(position)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    tick();
  endtask

  task automatic issue(input logic d, input logic [15:0] s, input logic [15:0] w);
    cmd_dir = d; cmd_steps = s; cmd_dwell = w; cmd_valid = 1'b1;
    n_cmp++;
    if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL issue_ready got=%b exp=1", cmd_ready); end
    tick();
    cmd_valid = 1'b0;
    cmd_dir = ~d; cmd_steps = 16'd99; cmd_dwell = 16'd1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #3;
    n_cmp++;
    if ({enc_a, enc_b, busy, done, cmd_ready} !== 5'b0 || position !== 24'd0) begin
      n_bad++; $display("FAIL reset_vals got=%b%b%b%b%b pos=%h exp=00000 pos=0", enc_a, enc_b, busy, done, cmd_ready, position);
    end
    tick();
    rst = 1'b1;
    tick();
    n_cmp++;
    if (cmd_ready !== 1'b0) begin n_bad++; $display("FAIL ready_sync1 got=%b exp=0", cmd_ready); end
    tick();
    n_cmp++;
    if (cmd_ready !== 1'b1) begin n_bad++; $display("FAIL ready_sync2 got=%b exp=1", cmd_ready); end
  endtask

  task automatic test_forward();
    logic [1:0] seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    logic [1:0] exp_ph;
    int n;
    issue(1'b1, 16'd4, 16'd3);
    for (int k = 1; k <= 13; k++) begin
      tick();
      n = k / 3 > 4 ? 4 : k / 3;
      exp_ph = seq[n % 4];
      n_cmp++;
      if ({enc_a, enc_b} !== exp_ph) begin n_bad++; $display("FAIL fwd_phase k=%0d got=%b%b exp=%b", k, enc_a, enc_b, exp_ph); end
      n_cmp++;
      if (done !== (k == 13)) begin n_bad++; $display("FAIL fwd_done k=%0d got=%b exp=%b", k, done, k == 13); end
      n_cmp++;
      if (busy !== (k < 13)) begin n_bad++; $display("FAIL fwd_busy k=%0d got=%b exp=%b", k, busy, k < 13); end
    end
    n_cmp++;
    if (position !== 24'd4) begin n_bad++; $display("FAIL fwd_pos got=%h exp=000004", position); end
    tick();
    n_cmp++;
    if (cmd_ready !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL fwd_idle ready=%b done=%b exp=1,0", cmd_ready, done); end
  endtask

  task automatic test_reverse_dwell0();
    do_reset();
    issue(1'b0, 16'd2, 16'd0);
    tick();
    n_cmp++;
    if ({enc_a, enc_b} !== 2'b01 || position !== 24'hFFFFFF) begin n_bad++; $display("FAIL rev_step1 got=%b%b pos=%h exp=01 pos=ffffff", enc_a, enc_b, position); end
    tick();
    n_cmp++;
    if ({enc_a, enc_b} !== 2'b11 || position !== 24'hFFFFFE) begin n_bad++; $display("FAIL rev_step2 got=%b%b pos=%h exp=11 pos=fffffe", enc_a, enc_b, position); end
    tick();
    n_cmp++;
    if (done !== 1'b1 || {enc_a, enc_b} !== 2'b11) begin n_bad++; $display("FAIL rev_done done=%b ph=%b%b exp=1 11", done, enc_a, enc_b); end
  endtask

  task automatic test_zero_steps();
    tick();
    issue(1'b1, 16'd0, 16'd4);
    tick();
    n_cmp++;
    if (done !== 1'b1 || {enc_a, enc_b} !== 2'b11 || position !== 24'hFFFFFE) begin
      n_bad++; $display("FAIL zero_done done=%b ph=%b%b pos=%h exp=1 11 fffffe", done, enc_a, enc_b, position);
    end
    tick();
    n_cmp++;
    if (cmd_ready !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL zero_ready ready=%b done=%b exp=1,0", cmd_ready, done); end
  endtask

  task automatic test_abort();
    do_reset();
    abort = 1'b1;
    tick();
    n_cmp++;
    if (cmd_ready !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL abort_idle ready=%b done=%b exp=1,0", cmd_ready, done); end
    abort = 1'b0;
    issue(1'b1, 16'd100, 16'd5);
    repeat (11) tick();
    n_cmp++;
    if (busy !== 1'b1 || {enc_a, enc_b} !== 2'b11) begin n_bad++; $display("FAIL abort_pre busy=%b ph=%b%b exp=1 11", busy, enc_a, enc_b); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0) begin n_bad++; $display("FAIL abort_done done=%b busy=%b exp=1,0", done, busy); end
    n_cmp++;
    if ({enc_a, enc_b} !== 2'b11 || position !== 24'd2) begin n_bad++; $display("FAIL abort_pos ph=%b%b pos=%h exp=11 000002", enc_a, enc_b, position); end
    repeat (6) tick();
    n_cmp++;
    if ({enc_a, enc_b} !== 2'b11 || position !== 24'd2 || cmd_ready !== 1'b1) begin
      n_bad++; $display("FAIL abort_hold ph=%b%b pos=%h ready=%b exp=11 000002 1", enc_a, enc_b, position, cmd_ready);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    issue(1'b1, 16'd10, 16'd2);
    repeat (7) tick();
    n_cmp++;
    if ({enc_a, enc_b} !== 2'b01 || position !== 24'd3) begin n_bad++; $display("FAIL mid_pre ph=%b%b pos=%h exp=01 000003", enc_a, enc_b, position); end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({enc_a, enc_b, busy, done, cmd_ready} !== 5'b0 || position !== 24'd0) begin
      n_bad++; $display("FAIL mid_reset got=%b%b%b%b%b pos=%h exp=00000 pos=0", enc_a, enc_b, busy, done, cmd_ready, position);
    end
    tick();
    rst = 1'b1;
    tick();
    tick();
    issue(1'b0, 16'd1, 16'd1);
    tick();
    n_cmp++;
    if ({enc_a, enc_b} !== 2'b01 || position !== 24'hFFFFFF) begin n_bad++; $display("FAIL mid_after ph=%b%b pos=%h exp=01 ffffff", enc_a, enc_b, position); end
    tick();
    n_cmp++;
    if (done !== 1'b1) begin n_bad++; $display("FAIL mid_after_done got=%b exp=1", done); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    cmd_dir = 1'b1; cmd_steps = 16'd1; cmd_dwell = 16'd2; cmd_valid = 1'b1;
    tick();
    tick();
    n_cmp++;
    if ({enc_a, enc_b} !== 2'b00) begin n_bad++; $display("FAIL b2b_e1 got=%b%b exp=00", enc_a, enc_b); end
    tick();
    n_cmp++;
    if ({enc_a, enc_b} !== 2'b10 || position !== 24'd1) begin n_bad++; $display("FAIL b2b_e2 ph=%b%b pos=%h exp=10 000001", enc_a, enc_b, position); end
    tick();
    n_cmp++;
    if (done !== 1'b1 || cmd_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_done done=%b ready=%b exp=1,0", done, cmd_ready); end
    tick();
    n_cmp++;
    if (cmd_ready !== 1'b1 || done !== 1'b0) begin n_bad++; $display("FAIL b2b_ready ready=%b done=%b exp=1,0", cmd_ready, done); end
    tick();
    cmd_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || cmd_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_accept2 busy=%b ready=%b exp=1,0", busy, cmd_ready); end
    tick();
    n_cmp++;
    if ({enc_a, enc_b} !== 2'b10) begin n_bad++; $display("FAIL b2b_e6 got=%b%b exp=10", enc_a, enc_b); end
    tick();
    n_cmp++;
    if ({enc_a, enc_b} !== 2'b11 || position !== 24'd2) begin n_bad++; $display("FAIL b2b_e7 ph=%b%b pos=%h exp=11 000002", enc_a, enc_b, position); end
    tick();
    n_cmp++;
    if (done !== 1'b1) begin n_bad++; $display("FAIL b2b_done2 got=%b exp=1", done); end
  endtask

  initial begin
    test_reset();
    test_forward();
    test_reverse_dwell0();
    test_zero_steps();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
